// File: rtl/xintf_dpbram_arbiter.sv
// Round-robin, burst-oriented arbiter sharing the XINTF DPBRAM write port (port A) among N_REQ requesters.
// Latency: request to grant is 1 cycle; owner write beat to DPBRAM pins is 1 cycle; a release leaves 1 dead cycle.
// Backpressure: requesters hold i_req until granted; writes from non-owners are dropped, and owners are force-released at MAX_BURST beats.
module xintf_dpbram_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 64,
    localparam int OWN_W    = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ-1:0]           i_last,
    input  logic [N_REQ-1:0]           i_we,
    input  logic [N_REQ*ADDR_W-1:0]    i_addr,
    input  logic [N_REQ*DATA_W-1:0]    i_din,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [OWN_W-1:0]           o_owner,
    output logic [ADDR_W-1:0]          o_ram_addr,
    output logic [DATA_W-1:0]          o_ram_din,
    output logic                       o_ram_ce,
    output logic                       o_ram_we,
    output logic                       o_busy,
    output logic                       o_burst_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic [OWN_W-1:0]    last_owner_q, last_owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_wr_q, ram_wr_d;
    logic                err_q, err_d;

    // Round-robin winner: first requesting index after the previous owner.
    logic                win_vld;
    logic [OWN_W-1:0]    win_idx;
    logic [OWN_W-1:0]    cand;

    // The owner's own request lane; every other lane is ignored.
    logic                own_req;
    logic                own_we;
    logic                own_last;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_din;

    assign own_req  = i_req[owner_q];
    assign own_we   = i_we[owner_q];
    assign own_last = i_last[owner_q];
    assign own_addr = i_addr[int'(owner_q) * ADDR_W +: ADDR_W];
    assign own_din  = i_din[int'(owner_q) * DATA_W +: DATA_W];

    // Scan last_owner+1, last_owner+2, ... (mod N_REQ) for the first active request.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = OWN_W'((int'(last_owner_q) + i) % N_REQ);
            if (!win_vld && i_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/GRANT/RELEASE machine.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_wr_d     = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (win_vld) begin
                    state_d = S_GRANT;
                    gnt_d   = N_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    cnt_d   = '0;
                end
            end

            S_GRANT: begin
                if (!own_req) begin
                    // Owner withdrew: its strobe this cycle is discarded.
                    state_d      = S_RELEASE;
                    gnt_d        = '0;
                    last_owner_d = owner_q;
                end else if (own_we) begin
                    ram_wr_d   = 1'b1;
                    ram_addr_d = own_addr;
                    ram_din_d  = own_din;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (own_last) begin
                        state_d      = S_RELEASE;
                        gnt_d        = '0;
                        last_owner_d = owner_q;
                    end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        // This beat is the MAX_BURST-th: write it, then force the port free.
                        state_d      = S_RELEASE;
                        gnt_d        = '0;
                        last_owner_d = owner_q;
                        err_d        = 1'b1;
                    end
                end
            end

            S_RELEASE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides everything, even mid-burst.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= OWN_W'(N_REQ - 1);
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_wr_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_wr_q     <= ram_wr_d;
            err_q        <= err_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_owner     = owner_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_din   = ram_din_q;
    assign o_ram_ce    = ram_wr_q;
    assign o_ram_we    = ram_wr_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_burst_err = err_q;

endmodule

// File: tb/tb_xintf_dpbram_arbiter.sv
// Bench for xintf_dpbram_arbiter: two instances (MAX_BURST 64 and 4) driven with identical stimulus.
// Latency: a transaction-level model predicts every output one edge ahead; outputs are compared on each falling edge.
// Backpressure: directed scenarios plus a randomized phase; every wait for a grant is bounded.
module tb_xintf_dpbram_arbiter;

    localparam int N  = 3;
    localparam int AW = 9;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      last = '0;
    logic [N-1:0]      we = '0;
    logic [N*AW-1:0]   addr = '0;
    logic [N*DW-1:0]   din = '0;

    logic [1:0][N-1:0]  gnt;
    logic [1:0][1:0]    owner;
    logic [1:0][AW-1:0] raddr;
    logic [1:0][DW-1:0] rdin;
    logic [1:0]         ce, rwe, busy, berr;

    xintf_dpbram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(64)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_last(last), .i_we(we),
        .i_addr(addr), .i_din(din), .o_gnt(gnt[0]), .o_owner(owner[0]),
        .o_ram_addr(raddr[0]), .o_ram_din(rdin[0]), .o_ram_ce(ce[0]),
        .o_ram_we(rwe[0]), .o_busy(busy[0]), .o_burst_err(berr[0])
    );

    xintf_dpbram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_last(last), .i_we(we),
        .i_addr(addr), .i_din(din), .o_gnt(gnt[1]), .o_owner(owner[1]),
        .o_ram_addr(raddr[1]), .o_ram_din(rdin[1]), .o_ram_ce(ce[1]),
        .o_ram_we(rwe[1]), .o_busy(busy[1]), .o_burst_err(berr[1])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int mb_of(input int m);
        return (m == 0) ? 64 : 4;
    endfunction

    // ---------------- behavioural model ----------------
    // m_act: current owner or -1; m_rel: dead cycle pending; m_beats: beats written this grant.
    int              m_act[2];
    int              m_rel[2];
    int              m_last[2];
    int              m_cur[2];
    int              m_beats[2];
    logic            e_wr[2];
    logic            e_err[2];
    logic [AW-1:0]   e_addr[2];
    logic [DW-1:0]   e_din[2];

    always @(posedge clk) begin
        int  k;
        int  j;
        bit  drop;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_act[m]   = -1;
                m_rel[m]   = 0;
                m_last[m]  = N - 1;
                m_cur[m]   = 0;
                m_beats[m] = 0;
                e_wr[m]    = 1'b0;
                e_err[m]   = 1'b0;
                e_addr[m]  = '0;
                e_din[m]   = '0;
            end else begin
                e_wr[m]  = 1'b0;
                e_err[m] = 1'b0;
                if (m_act[m] >= 0) begin
                    k    = m_act[m];
                    drop = 0;
                    if (!req[k]) begin
                        drop = 1;
                    end else if (we[k]) begin
                        e_wr[m]   = 1'b1;
                        e_addr[m] = addr[k*AW +: AW];
                        e_din[m]  = din[k*DW +: DW];
                        m_beats[m] = m_beats[m] + 1;
                        if (last[k]) begin
                            drop = 1;
                        end else if (m_beats[m] == mb_of(m)) begin
                            drop = 1;
                            e_err[m] = 1'b1;
                        end
                    end
                    if (drop) begin
                        m_act[m]  = -1;
                        m_rel[m]  = 1;
                        m_last[m] = k;
                    end
                end else if (m_rel[m] != 0) begin
                    m_rel[m] = 0;
                end else begin
                    for (int i = 1; i <= N; i++) begin
                        j = (m_last[m] + i) % N;
                        if (m_act[m] < 0 && req[j]) begin
                            m_act[m]   = j;
                            m_cur[m]   = j;
                            m_beats[m] = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- compare process + observation stats ----------------
    int wr_cnt[2];
    int err_cnt[2];
    bit saw_1ff[2];
    bit saw_10[2];

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [1:0]   eo;
        logic         eb;
        for (int m = 0; m < 2; m++) begin
            eg = (m_act[m] >= 0) ? (N'(1) << m_act[m]) : '0;
            eo = m_cur[m][1:0];
            eb = (m_act[m] >= 0) || (m_rel[m] != 0);
            check($sformatf("dut%0d_ctrl{gnt,owner,ce,we,busy,err}", m),
                  64'({gnt[m], owner[m], ce[m], rwe[m], busy[m], berr[m]}),
                  64'({eg, eo, e_wr[m], e_wr[m], eb, e_err[m]}));
            check($sformatf("dut%0d_data{addr,din}", m),
                  64'({raddr[m], rdin[m]}), 64'({e_addr[m], e_din[m]}));
            if (ce[m] === 1'b1 && rwe[m] === 1'b1) begin
                wr_cnt[m]++;
                if (raddr[m] == 9'h1FF) saw_1ff[m] = 1;
                if (raddr[m] == 9'h010) saw_10[m] = 1;
            end
            if (berr[m] === 1'b1) err_cnt[m]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req  = '0;
        we   = '0;
        last = '0;
        addr = '0;
        din  = '0;
    endtask

    task automatic set_beat(input int k, input int a, input int d, input bit l);
        we   = '0;
        last = '0;
        we[k]   = 1'b1;
        last[k] = l;
        addr[k*AW +: AW] = AW'(a);
        din[k*DW +: DW]  = DW'(d);
    endtask

    task automatic clr_stats();
        for (int m = 0; m < 2; m++) begin
            wr_cnt[m]  = 0;
            err_cnt[m] = 0;
            saw_1ff[m] = 0;
            saw_10[m]  = 0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clr_stats();
    endtask

    int ord[4];
    int exp_ord[4] = '{0, 1, 2, 0};
    int k;

    initial begin
        // Reset state
        idle_inputs();
        tick();
        tick();
        check("reset_gnt", 64'(gnt[0]), 64'(0));
        check("reset_busy", 64'(busy[0]), 64'(0));
        check("reset_ram_ce", 64'(ce[1]), 64'(0));
        rst = 1'b0;
        clr_stats();

        // Single requester: 5 beats, last on beat 4
        req = 3'b001;
        tick();
        check("t1_gnt_latency", 64'(gnt[0]), 64'(3'b001));
        for (int n = 0; n < 5; n++) begin
            set_beat(0, n, 16'hA000 + n, n == 4);
            tick();
            check($sformatf("t1_ram_addr%0d", n), 64'(raddr[0]), 64'(n));
            check($sformatf("t1_ram_din%0d", n), 64'(rdin[0]), 64'(16'hA000 + n));
        end
        idle_inputs();
        check("t1_release_busy", 64'(busy[0]), 64'(1));
        check("t1_release_gnt", 64'(gnt[0]), 64'(0));
        tick();
        check("t1_idle_busy", 64'(busy[0]), 64'(0));
        check("t1_writes_mb64", 64'(wr_cnt[0]), 64'(5));
        check("t1_writes_mb4", 64'(wr_cnt[1]), 64'(4));
        check("t1_bursterr_mb4", 64'(err_cnt[1]), 64'(1));

        // Contention: all three request, each owner writes two beats with last
        do_reset();
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            for (int w = 0; w < 10 && gnt[0] == '0; w++) tick();
            check($sformatf("t2_grant_wait%0d", g), 64'(gnt[0] != '0), 64'(1));
            k = gnt[0][0] ? 0 : (gnt[0][1] ? 1 : 2);
            ord[g] = k;
            set_beat(k, 32 + 2 * g, 16'hC000 + g, 0);
            tick();
            set_beat(k, 33 + 2 * g, 16'hC100 + g, 1);
            tick();
            we   = '0;
            last = '0;
        end
        for (int g = 0; g < 4; g++)
            check($sformatf("t2_order%0d", g), 64'(ord[g]), 64'(exp_ord[g]));
        idle_inputs();
        tick();
        tick();

        // Burst limit: owner 1 writes 6 beats without last, requester 2 pending
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b110;
        for (int n = 0; n < 6; n++) begin
            set_beat(1, 64 + n, 16'hB000 + n, 0);
            tick();
        end
        check("t3_gnt_passes_mb4", 64'(gnt[1]), 64'(3'b100));
        check("t3_gnt_held_mb64", 64'(gnt[0]), 64'(3'b010));
        idle_inputs();
        tick();
        tick();
        check("t3_writes_mb4", 64'(wr_cnt[1]), 64'(4));
        check("t3_bursterr_mb4", 64'(err_cnt[1]), 64'(1));
        check("t3_writes_mb64", 64'(wr_cnt[0]), 64'(6));
        check("t3_bursterr_mb64", 64'(err_cnt[0]), 64'(0));

        // Abort: owner drops req while strobing addr 0x10
        do_reset();
        req = 3'b001;
        tick();
        set_beat(0, 5, 16'h1234, 0);
        tick();
        req = 3'b000;
        set_beat(0, 16, 16'hDEAD, 0);
        tick();
        check("t4_gnt_dropped", 64'(gnt[0]), 64'(0));
        check("t4_no_ce", 64'(ce[0]), 64'(0));
        idle_inputs();
        tick();
        check("t4_no_write_0x10", 64'({saw_10[0], saw_10[1]}), 64'(0));

        // Reset mid-burst after 3 beats
        do_reset();
        req = 3'b001;
        tick();
        for (int n = 0; n < 3; n++) begin
            set_beat(0, 80 + n, 16'h5A00 + n, 0);
            tick();
        end
        rst = 1'b1;
        set_beat(0, 83, 16'h5A03, 0);
        tick();
        for (int m = 0; m < 2; m++)
            check($sformatf("t5_outputs_zero_dut%0d", m),
                  64'({gnt[m], owner[m], ce[m], rwe[m], busy[m], berr[m], raddr[m], rdin[m]}), 64'(0));
        rst = 1'b0;
        idle_inputs();
        req = 3'b110;
        tick();
        check("t5_rr_restart_gnt", 64'(gnt[0]), 64'(3'b010));
        check("t5_rr_restart_owner", 64'(owner[1]), 64'(1));
        idle_inputs();
        tick();
        tick();

        // Intruder: non-owner 2 strobes 0x1FF while 0 owns the port
        do_reset();
        req = 3'b101;
        tick();
        for (int n = 0; n < 4; n++) begin
            set_beat(0, 96 + n, 16'h7700 + n, n == 3);
            we[2]   = 1'b1;
            last[2] = 1'b1;
            addr[2*AW +: AW] = 9'h1FF;
            din[2*DW +: DW]  = 16'hFFFF;
            tick();
        end
        idle_inputs();
        tick();
        tick();
        check("t6_no_intruder_write", 64'({saw_1ff[0], saw_1ff[1]}), 64'(0));
        check("t6_owner_writes", 64'(wr_cnt[0]), 64'(4));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
                we[b]   = 1'($urandom_range(0, 1));
                last[b] = ($urandom_range(0, 5) == 0);
            end
            addr = (N*AW)'({$urandom(), $urandom()});
            din  = (N*DW)'({$urandom(), $urandom()});
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xintf_dpbram_arbiter.md
Name: xintf_dpbram_arbiter

Overview:
- Shares the single XINTF DPBRAM write port between up to N_REQ requesters, for example the periodic DSP parameter/ADC writer, the waveform table loader and the PS register mirror.
- Grants are round-robin and burst-oriented: one owner holds the port until it releases or hits a burst limit.
- Sits between the requesters and the DPBRAM port A pins. The DPBRAM read side is outside its scope.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 9, DPBRAM address width
- DATA_W, 16, DPBRAM data width
- MAX_BURST, 64, maximum write beats per grant before a forced release (1..511)

Ports:
- i_clk  in  1  system clock; sole clock domain
- i_rst  in  1  synchronous, active-high reset
- i_req  in  N_REQ  per-requester request level; held high while the port is wanted
- i_last  in  N_REQ  qualifies the final beat; meaningful only together with i_we and a grant
- i_we  in  N_REQ  per-requester write strobe; honoured only while that requester is granted
- i_addr  in  N_REQ*ADDR_W  flattened addresses; requester k uses bits [k*ADDR_W +: ADDR_W]
- i_din  in  N_REQ*DATA_W  flattened write data, same packing as i_addr
- o_gnt  out  N_REQ  one-hot grant, registered
- o_owner  out  ceil(log2(N_REQ))  index of the current or most recent owner
- o_ram_addr  out  ADDR_W  DPBRAM address, registered
- o_ram_din  out  DATA_W  DPBRAM write data, registered
- o_ram_ce  out  1  DPBRAM enable, registered
- o_ram_we  out  1  DPBRAM write enable, registered
- o_busy  out  1  high in GRANT and RELEASE
- o_burst_err  out  1  one-cycle pulse when a grant is force-released at MAX_BURST

Behaviour:
- Reset (i_rst=1 at a clock edge; dominates every other event, including mid-burst):
  - state=IDLE; all outputs 0.
  - Burst counter is cleared.
  - last_owner=N_REQ-1, so requester 0 wins the first arbitration.
  - No DPBRAM write is issued on the reset cycle or the cycle after it.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any i_req bit is set, choose the first set bit scanning last_owner+1, last_owner+2, ... modulo N_REQ.
  - Next cycle: o_gnt is one-hot at the winner, o_owner updates, burst counter=0, state=GRANT.
  - Latency from req to gnt: 1 cycle.
- GRANT (owner k):
  - Each cycle with i_we[k]=1: next cycle o_ram_ce=o_ram_we=1, with o_ram_addr/o_ram_din taken from requester k. Address/data latency is 1 cycle.
  - Each such beat increments the burst counter.
  - Cycles with i_we[k]=0 drive o_ram_ce=o_ram_we=0; addr/din hold their last values.
- Release conditions, in priority order:
  - (a) i_req[k]=0: that cycle's i_we[k] is ignored.
  - (b) i_we[k]&i_last[k]: that beat is written.
  - (c) burst counter reaches MAX_BURST-1 on a write beat: that beat is written and o_burst_err pulses on the next cycle.
  - On any release: o_gnt=0 next cycle, state=RELEASE, last_owner=k.
- RELEASE:
  - Exactly one dead cycle: o_ram_ce=o_ram_we=0, o_gnt=0.
  - Then IDLE. Re-arbitration occurs in IDLE, so the minimum gap between two owners' beats is 2 cycles.
- Non-owner signals:
  - i_we/i_last from non-granted requesters are ignored in every state.
  - A non-owner dropping i_req has no effect.
- Grant held by an owner whose i_req stays high with no writes: held indefinitely. MAX_BURST counts beats, not cycles.
- Burst counter width is ceil(log2(MAX_BURST+1)); it never wraps because release occurs at MAX_BURST beats.
- o_owner retains its value outside GRANT.

Test Plan:
- Single requester: req[0]=1, write addr 0..4 with data 0xA000+n, last on beat 4. Required: gnt[0] one cycle after req; RAM sees 5 writes, each 1 cycle after its i_we; then 1 RELEASE cycle, then IDLE.
- Contention: req[2:0]=3'b111 held; each owner writes 2 beats with last. Required: grant order 0,1,2,0; ≥2 idle cycles between owners' writes; no overlap of o_gnt bits.
- Burst limit, MAX_BURST=4: owner 1 writes 6 beats without last. Required: only 4 RAM writes; o_burst_err pulses once; grant passes to requester 2 when pending.
- Abort: owner 0 drops req on the same cycle as i_we=1, addr 0x10. Required: no write to 0x10; o_gnt=0 next cycle.
- Reset mid-burst: i_rst=1 during GRANT after 3 beats. Required: next cycle all outputs 0, state IDLE; after reset, with req=3'b110, requester 1 wins.
- Intruder: non-owner 2 pulses i_we with addr 0x1FF while 0 is owner. Required: RAM never sees 0x1FF.
